mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive data grants made while an instruction request waits.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles a grant may wait for the RAM.
REQ-003 SHALL have port CLK  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iREN  input  1  instruction read request from the datapath.
REQ-006 SHALL have port iaddr  input  32  instruction word address.
REQ-007 SHALL have ports dREN / dWEN  input  1 each  data read / write request.
REQ-008 SHALL have ports daddr / dstore  input  32 each  data address / write data.
REQ-009 SHALL have ports ihit / dhit  output  1 each  one-cycle completion pulse.
REQ-010 SHALL have ports iload / dload  output  32 each  read data to the datapath.
REQ-011 SHALL have ports ramREN / ramWEN  output  1 each  RAM read / write strobes.
REQ-012 SHALL have ports ramaddr / ramstore  output  32 each  RAM address / write data.
REQ-013 SHALL have port ramload  input  32  RAM read data.
REQ-014 SHALL have port ramstate  input  ramstate_t  RAM status: FREE, BUSY, ACCESS or ERROR.
REQ-015 SHALL have port arb_busy  output  1  high while a grant is outstanding.
REQ-016 SHALL have port timeout_err  output  1  sticky flag, set when TIMEOUT is exceeded.

Function
REQ-017 SHALL implement an FSM with states IDLE, IGRANT and DGRANT.
REQ-018 IDLE selection: data request (dREN|dWEN) wins over iREN, except when iREN is high and starve_cnt==STARVE_LIMIT, in which case iREN wins; with no request, stay in IDLE.
REQ-019 The grant decision SHALL be registered, so the RAM is driven starting the cycle after a request is seen in IDLE.
REQ-020 IGRANT SHALL drive ramREN=1, ramWEN=0 and ramaddr={iaddr[31:2],2'b00}.
REQ-021 DGRANT SHALL drive ramaddr={daddr[31:2],2'b00} and ramstore=dstore; with dWEN=1 it drives ramWEN=1, ramREN=0 (write wins if dREN and dWEN are both high); otherwise ramREN=1.
REQ-022 In IDLE, ramREN, ramWEN, ramaddr and ramstore SHALL all be 0.
REQ-023 In a grant state with ramstate==ACCESS, the FSM SHALL pulse the matching hit for exactly that cycle, combinationally, and go to IDLE next cycle.
REQ-024 iload and dload SHALL equal ramload while their hit is high and 0 otherwise.
REQ-025 ramstate BUSY or FREE SHALL hold the grant state; ERROR SHALL hold the grant state with strobes asserted (retry), with no hit.
REQ-026 If the granted request drops before ACCESS (iREN=0 in IGRANT; dREN=dWEN=0 in DGRANT), the FSM SHALL abort to IDLE next cycle with no hit.
REQ-027 starve_cnt (3 bits) SHALL increment, saturating at STARVE_LIMIT, on each dhit that occurs while iREN=1.
REQ-028 starve_cnt SHALL clear on ihit and hold otherwise.
REQ-029 wait_cnt (8 bits) SHALL clear on entry to a grant state and increment each grant cycle without ACCESS.
REQ-030 When wait_cnt reaches TIMEOUT, timeout_err SHALL set and stay set until reset; the grant continues.
REQ-031 arb_busy SHALL equal (state!=IDLE).
REQ-032 The hit cycle and the next request SHALL NOT overlap; a request still present after the hit is re-arbitrated from IDLE.

Reset
REQ-033 On nRST low, asynchronously: state=IDLE, starve_cnt=0, wait_cnt=0, timeout_err=0.
REQ-034 While nRST is low, all outputs SHALL be 0.
REQ-035 Reset asserted mid-grant SHALL abandon the access with no hit; after release, arbitration restarts from IDLE.

Structure
REQ-036 ramstate_t (FREE, BUSY, ACCESS, ERROR) and arb_state_t (IDLE, IGRANT, DGRANT) SHALL live in cpu_types_pkg.
REQ-037 The block SHALL be a single module with no sub-modules.
REQ-038 The block SHALL sit between the datapath/cache interface and the RAM.

Verification
REQ-039 Reset, then iREN=1, iaddr=0x0000_0004, ramstate=ACCESS on the second cycle -> ramREN=1, ramaddr=0x4, one-cycle ihit, iload=ramload.
REQ-040 iREN and dWEN asserted in the same cycle, daddr=0x80, dstore=0xDEAD_BEEF -> DGRANT first, ramWEN=1, dhit; then IGRANT and ihit.
REQ-041 iREN held, with 5 back-to-back data requests -> starve_cnt reaches 4, the fifth data request loses, and ihit occurs before the fifth dhit.
REQ-042 ramstate=BUSY for 3 cycles, then ERROR for 1 cycle, then ACCESS -> strobes held for 5 cycles, exactly one dhit, dload=0 except in the hit cycle.
REQ-043 ramstate=BUSY for 256 cycles -> timeout_err rises at wait_cnt==255 and stays high after the eventual ACCESS and hit.
REQ-044 iaddr=0x13, and separately nRST pulsed low mid-DGRANT -> ramaddr=0x10 for the first; for the second, all outputs are 0 immediately with no dhit, and normal arbitration follows after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, arbiter FSM state, counter widths.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    typedef logic [2:0] starve_cnt_t;
    typedef logic [7:0] wait_cnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requests onto a single RAM port.
// Data normally wins; an instruction fetch starved for STARVE_LIMIT data grants wins next.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        arb_busy,
    output logic        timeout_err
);

    localparam starve_cnt_t StarveMax  = starve_cnt_t'(STARVE_LIMIT);
    localparam wait_cnt_t   TimeoutVal = wait_cnt_t'(TIMEOUT);

    arb_state_t  state_q, state_d;
    starve_cnt_t starve_cnt_q, starve_cnt_d;
    wait_cnt_t   wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic d_req;
    logic ram_access;
    logic unused_addr_lsbs;

    assign d_req      = dREN | dWEN;
    assign ram_access = (ramstate == ACCESS);
    // Byte offsets are dropped: the RAM is word addressed.
    assign unused_addr_lsbs = ^{iaddr[1:0], daddr[1:0]};

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state: registered grant decision; leave a grant on ACCESS or when the request drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req && !(iREN && (starve_cnt_q == StarveMax))) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                if (!iREN || ram_access) begin
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                if (!d_req || ram_access) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: RAM strobes follow the grant state; hits are combinational on ACCESS.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        case (state_q)
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = {iaddr[31:2], 2'b00};
                ihit    = iREN & ram_access;
            end
            DGRANT: begin
                ramaddr  = {daddr[31:2], 2'b00};
                ramstore = dstore;
                // A simultaneous read and write request is treated as a write.
                if (dWEN) begin
                    ramWEN = 1'b1;
                end else begin
                    ramREN = 1'b1;
                end
                dhit = d_req & ram_access;
            end
            default: ;
        endcase
        iload       = ihit ? ramload : '0;
        dload       = dhit ? ramload : '0;
        arb_busy    = (state_q != IDLE);
        timeout_err = timeout_err_q;
    end

    // Starvation and wait counters plus the sticky timeout flag.
    always_comb begin
        starve_cnt_d  = starve_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;

        if (ihit) begin
            starve_cnt_d = '0;
        end else if (dhit && iREN && (starve_cnt_q < StarveMax)) begin
            starve_cnt_d = starve_cnt_q + starve_cnt_t'(1);
        end

        if (state_q == IDLE) begin
            wait_cnt_d = '0;
        end else if (!ram_access) begin
            if (wait_cnt_q != '1) begin
                wait_cnt_d = wait_cnt_q + wait_cnt_t'(1);
            end
            if (wait_cnt_d == TimeoutVal) begin
                timeout_err_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed corner cases plus randomized traffic against a
// transaction-level arbitration/memory model, checked by a hit-driven scoreboard.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] ramload = '0;
    ramstate_t   ramstate = FREE;
    logic        ihit, dhit, ramREN, ramWEN, arb_busy, timeout_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct { bit is_d; bit is_wr; logic [31:0] addr; logic [31:0] data; } exp_t;
    typedef struct { bit wr; bit rd; logic [31:0] addr; logic [31:0] data; } dreq_t;

    exp_t        exp_q[$];
    dreq_t       dq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ram_mem [64];
    logic [31:0] ref_mem [64];
    bit          auto_ram = 1'b0;
    bit          rand_lat = 1'b0;
    ramstate_t   man_state = FREE;
    logic [31:0] man_load = '0;
    int          m_starve = 0;

    function automatic void check32(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [5:0] word_idx(logic [31:0] a);
        return a[7:2];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    // RAM model: manual mode replays man_state, auto mode answers after a random latency.
    initial begin : responder
        int cnt;
        int lat;
        cnt = 0;
        lat = 0;
        forever begin
            @(posedge CLK);
            #2;
            if (!auto_ram) begin
                ramstate = man_state;
                ramload  = man_load;
                cnt      = 0;
            end else if (ramREN || ramWEN) begin
                if (cnt == 0) lat = rand_lat ? int'($urandom_range(0, 3)) : 0;
                if (cnt >= lat) begin
                    ramstate = ACCESS;
                    if (ramWEN) begin
                        ram_mem[word_idx(ramaddr)] = ramstore;
                        ramload = $urandom;
                    end else begin
                        ramload = ram_mem[word_idx(ramaddr)];
                    end
                    cnt = 0;
                end else begin
                    case ($urandom_range(0, 2))
                        0:       ramstate = FREE;
                        1:       ramstate = BUSY;
                        default: ramstate = ERROR;
                    endcase
                    cnt++;
                end
            end else begin
                ramstate = FREE;
                ramload  = $urandom;
                cnt      = 0;
            end
        end
    end

    // Scoreboard monitor: every hit pops one expected transaction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!ihit) check32("iload_gated", iload, 32'h0);
            if (!dhit) check32("dload_gated", dload, 32'h0);
            if (ihit && dhit) check32("dual_hit", 32'h1, 32'h0);
            if (ihit || dhit) begin
                if (exp_q.size() == 0) begin
                    check32("unexpected_hit", {30'b0, ihit, dhit}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check32("hit_kind", 32'(dhit), 32'(e.is_d));
                    check32("hit_addr", ramaddr, e.addr);
                    if (e.is_d && e.is_wr) begin
                        check32("wr_strobes", {30'b0, ramWEN, ramREN}, 32'h2);
                        check32("wr_data", ramstore, e.data);
                    end else begin
                        check32("rd_strobes", {30'b0, ramWEN, ramREN}, 32'h1);
                        check32(e.is_d ? "dload" : "iload", e.is_d ? dload : iload, e.data);
                    end
                end
            end
        end
    end

    task automatic apply_next_d();
        dreq_t d;
        if (dq.size() > 0) begin
            d      = dq.pop_front();
            dREN   = d.rd;
            dWEN   = d.wr;
            daddr  = d.addr;
            dstore = d.data;
        end else begin
            dREN = 1'b0;
            dWEN = 1'b0;
        end
    endtask

    // Retire requests as their hits appear; the next queued data request follows immediately.
    task automatic serve(input int budget);
        int n;
        bit gi, gd;
        n = 0;
        while ((iREN || dREN || dWEN) && n < budget) begin
            sample();
            gi = ihit;
            gd = dhit;
            step();
            if (gi) iREN = 1'b0;
            if (gd) apply_next_d();
            n++;
        end
        check32("serve_done", {29'b0, iREN, dREN, dWEN}, 32'h0);
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        dq.delete();
    endtask

    // Reference model: order transactions by the arbitration rules, resolve data against ref_mem.
    task automatic scenario(input bit use_i, input logic [31:0] ia, input dreq_t ds[$]);
        exp_t e;
        bit   i_pend;
        int   di;
        i_pend = use_i;
        di     = 0;
        while (i_pend || di < ds.size()) begin
            if (di < ds.size() && !(i_pend && m_starve == 4)) begin
                e.is_d  = 1'b1;
                e.is_wr = ds[di].wr;
                e.addr  = ds[di].addr & ~32'h3;
                if (ds[di].wr) begin
                    e.data = ds[di].data;
                    ref_mem[word_idx(ds[di].addr)] = ds[di].data;
                end else begin
                    e.data = ref_mem[word_idx(ds[di].addr)];
                end
                if (i_pend && m_starve < 4) m_starve++;
                di++;
            end else begin
                e.is_d  = 1'b0;
                e.is_wr = 1'b0;
                e.addr  = ia & ~32'h3;
                e.data  = ref_mem[word_idx(ia)];
                i_pend  = 1'b0;
                m_starve = 0;
            end
            exp_q.push_back(e);
        end
        dq    = ds;
        iREN  = use_i;
        iaddr = ia;
        apply_next_d();
        serve(80);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        exp_t  e;
        dreq_t ds[$];
        dreq_t d;
        int    hits;
        logic [31:0] v;

        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ram_mem[i] = v;
            ref_mem[i] = v;
        end

        // Reset with requests driven: outputs must stay quiet.
        dWEN = 1'b1; daddr = 32'h0000_0444; dstore = 32'hFFFF_FFFF; iREN = 1'b1;
        repeat (2) @(posedge CLK);
        sample();
        check32("rst_ctrl", {26'b0, ihit, dhit, ramREN, ramWEN, arb_busy, timeout_err}, 32'h0);
        check32("rst_ramaddr", ramaddr, 32'h0);
        check32("rst_ramstore", ramstore, 32'h0);
        step();
        dWEN = 1'b0; iREN = 1'b0;
        nRST = 1'b1;

        // Single instruction fetch, ACCESS in the first grant cycle.
        step();
        iREN = 1'b1; iaddr = 32'h0000_0004; man_state = ACCESS; man_load = 32'hCAFE_0004;
        sample();
        check32("i_idle_ramren", {31'b0, ramREN}, 32'h0);
        check32("i_idle_busy", {31'b0, arb_busy}, 32'h0);
        e = '{is_d: 1'b0, is_wr: 1'b0, addr: 32'h4, data: 32'hCAFE_0004};
        exp_q.push_back(e);
        step();
        sample();
        check32("i_grant_ramren", {31'b0, ramREN}, 32'h1);
        check32("i_grant_ramaddr", ramaddr, 32'h4);
        check32("i_grant_ihit", {31'b0, ihit}, 32'h1);
        check32("i_grant_busy", {31'b0, arb_busy}, 32'h1);
        step();
        iREN = 1'b0; man_state = FREE;
        sample();
        check32("i_after_ihit", {30'b0, ihit, arb_busy}, 32'h0);

        // Simultaneous fetch and store: data first, then the fetch.
        auto_ram = 1'b1; rand_lat = 1'b0;
        step();
        ds.delete();
        d = '{wr: 1'b1, rd: 1'b0, addr: 32'h0000_0080, data: 32'hDEAD_BEEF};
        ds.push_back(d);
        scenario(1'b1, 32'h0000_0040, ds);

        // Held fetch against five back-to-back data reads: fetch wins after four.
        ds.delete();
        for (int i = 0; i < 5; i++) begin
            d = '{wr: 1'b0, rd: 1'b1, addr: 32'h100 + 32'(4 * i), data: 32'h0};
            ds.push_back(d);
        end
        scenario(1'b1, 32'h0000_0020, ds);

        // BUSY x3, ERROR x1, ACCESS: strobes held for five cycles, one hit.
        auto_ram = 1'b0;
        step();
        dREN = 1'b1; daddr = 32'h0000_0101; man_state = BUSY; man_load = 32'h1234_5678;
        sample();
        hits = 0;
        for (int g = 0; g < 5; g++) begin
            step();
            man_state = (g < 3) ? BUSY : ((g == 3) ? ERROR : ACCESS);
            if (g == 4) begin
                e = '{is_d: 1'b1, is_wr: 1'b0, addr: 32'h100, data: 32'h1234_5678};
                exp_q.push_back(e);
            end
            sample();
            check32("retry_ramren", {31'b0, ramREN}, 32'h1);
            check32("retry_dload", dload, (g == 4) ? 32'h1234_5678 : 32'h0);
            if (dhit) hits++;
        end
        check32("retry_hit_count", 32'(hits), 32'h1);
        step();
        dREN = 1'b0; man_state = FREE;
        sample();
        check32("retry_done_busy", {31'b0, arb_busy}, 32'h0);

        // Fetch withdrawn in the same cycle ACCESS arrives: abort, no hit.
        step();
        iREN = 1'b1; iaddr = 32'h0000_0204; man_state = BUSY;
        sample();
        step();
        sample();
        check32("abort_grant", {30'b0, arb_busy, ramREN}, 32'h3);
        step();
        iREN = 1'b0; man_state = ACCESS;
        sample();
        check32("abort_nohit", {31'b0, ihit}, 32'h0);
        step();
        man_state = FREE;
        sample();
        check32("abort_idle", {31'b0, arb_busy}, 32'h0);

        // Long BUSY: sticky timeout once the wait count reaches 255.
        step();
        dREN = 1'b1; daddr = 32'h0000_0200; man_state = BUSY;
        sample();
        for (int k = 1; k <= 256; k++) begin
            step();
            sample();
            if (k == 255) check32("timeout_before", {31'b0, timeout_err}, 32'h0);
            if (k == 256) check32("timeout_at_255", {31'b0, timeout_err}, 32'h1);
        end
        step();
        man_state = ACCESS;
        e = '{is_d: 1'b1, is_wr: 1'b0, addr: 32'h200, data: 32'h1234_5678};
        exp_q.push_back(e);
        sample();
        check32("timeout_hit", {30'b0, dhit, timeout_err}, 32'h3);
        step();
        dREN = 1'b0; man_state = FREE;
        sample();
        check32("timeout_sticky", {30'b0, arb_busy, timeout_err}, 32'h1);

        // Unaligned fetch address is word aligned on the RAM side.
        step();
        iREN = 1'b1; iaddr = 32'h0000_0013; man_state = BUSY;
        sample();
        step();
        sample();
        check32("align_ramaddr", ramaddr, 32'h0000_0010);
        step();
        iREN = 1'b0;
        step();
        sample();
        check32("align_abort_idle", {31'b0, arb_busy}, 32'h0);

        // Reset during a data write grant: immediate quiet outputs, then re-arbitration.
        step();
        dWEN = 1'b1; daddr = 32'h0000_0300; dstore = 32'hA5A5_5A5A;
        sample();
        step();
        sample();
        check32("mid_rst_grant", {30'b0, ramWEN, arb_busy}, 32'h3);
        step();
        nRST = 1'b0;
        man_state = ACCESS;
        #1;
        check32("mid_rst_ctrl", {26'b0, ihit, dhit, ramREN, ramWEN, arb_busy, timeout_err},
                32'h0);
        check32("mid_rst_addr", ramaddr | ramstore, 32'h0);
        sample();
        check32("mid_rst_nohit", {31'b0, dhit}, 32'h0);
        step();
        e = '{is_d: 1'b1, is_wr: 1'b1, addr: 32'h300, data: 32'hA5A5_5A5A};
        exp_q.push_back(e);
        nRST = 1'b1;
        m_starve = 0;
        sample();
        check32("post_rst_idle", {31'b0, arb_busy}, 32'h0);
        step();
        sample();
        check32("post_rst_dhit", {31'b0, dhit}, 32'h1);
        step();
        dWEN = 1'b0; man_state = FREE;

        // Randomized traffic with random RAM latency.
        auto_ram = 1'b1; rand_lat = 1'b1;
        step();
        for (int s = 0; s < 150; s++) begin
            bit use_i;
            int nd;
            use_i = 1'($urandom_range(0, 1));
            nd    = int'($urandom_range(0, 5));
            if (!use_i && nd == 0) nd = 1;
            ds.delete();
            for (int j = 0; j < nd; j++) begin
                d.wr   = 1'($urandom_range(0, 1));
                d.rd   = d.wr ? 1'($urandom_range(0, 1)) : 1'b1;
                d.addr = $urandom;
                d.data = $urandom;
                ds.push_back(d);
            end
            scenario(use_i, $urandom, ds);
        end

        repeat (3) step();
        check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
